dfe_rate_ctrl: RTL and testbench
================================

// Module: dfe_rate_ctrl
// PURPOSE
//  Rate scheduler for the DFE decimation chain. Replaces per-stage free-running dividers
//  with one controller that emits single-cycle clock-enable strobes for N cascaded stages.
//  All stages run on one clock. Per-stage ratios are reprogrammed through a valid/ready port.
//  A new ratio set is applied only at a frame boundary, so stage phases never tear.
// PARAMETERS
//  N_STAGES   3   number of cascaded decimation stages
//  CNT_W      4   width of each ratio field and its stage counter
//  DEF_RATIO  3   ratio loaded into every stage at reset (must be >= MIN_RATIO)
// PORTS
//  clk_in     in   1               single system clock, all logic on its rising edge
//  rst        in   1               synchronous reset, active-high
//  start      in   1               level/pulse; IDLE -> RUN
//  stop       in   1               level/pulse; RUN/PEND -> IDLE
//  cfg_valid  in   1               new ratio set offered
//  cfg_ratio  in   N_STAGES*CNT_W  stage k ratio in bits [k*CNT_W +: CNT_W]
//  cfg_ready  out  1               controller can take a ratio set
//  cfg_err    out  1               1-cycle pulse: offered set rejected
//  stb_out    out  N_STAGES        per-stage single-cycle enable strobe
//  frame_stb  out  1               equals stb_out[N_STAGES-1]; marks the frame boundary
//  busy       out  1               state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, all counters 0, active ratios = DEF_RATIO, shadow cleared.
//   Outputs after reset: stb_out=0, frame_stb=0, busy=0, cfg_err=0, cfg_ready=1.
//   rst asserted mid-operation aborts on that edge; pending config is discarded.
//  States:
//   IDLE: counters held at 0. start -> RUN.
//   RUN: counting. Accepted cfg -> PEND. stop -> IDLE.
//   PEND: counting, shadow config waiting. frame_stb -> RUN and load shadow. stop -> IDLE.
//  Counters:
//   Stage 0 counter c0 increments every RUN/PEND cycle and wraps at r0-1.
//   Stage k>0 counter ck increments only when stb_out[k-1]=1, and wraps at rk-1.
//  Strobes:
//   stb_out[0] = busy & (c0==r0-1).
//   stb_out[k] = stb_out[k-1] & (ck==rk-1).
//   Strobes are a combinational decode of registered state; no input-to-output path.
//  Latency: with start sampled at edge e0, the first stb_out[0] is high in the r0-th cycle
//   after e0. The frame period is the product of all ratios, in cycles.
//  Config accept and handshake:
//   cfg_ready = (state != PEND). Transfer occurs on cfg_valid & cfg_ready.
//   In IDLE, the active ratios update on the transfer edge.
//   In RUN, the set goes to the shadow register; state -> PEND; cfg_ready drops next cycle.
//   In PEND, the shadow copies into the active ratios on the frame_stb edge. Every counter
//    wraps to 0 on that same edge, so the new ratios take effect from the next cycle.
//  Validation: any field < MIN_RATIO (2) rejects the whole set.
//   The transfer still completes. cfg_err pulses 1 cycle later. Active and shadow are unchanged.
//   No state change.
//  Simultaneous events:
//   stop with start: stop wins.
//   start while busy: ignored.
//   cfg transfer in RUN on a frame_stb cycle: held in shadow, applied at the next boundary.
//   stop in PEND: shadow discarded.
//   Ratio field at max (2^CNT_W-1): legal, no overflow.
// CONFIGURATION
//  DFE_RATE_LEVEL_EN defined: adds output lvl_out [N_STAGES].
//   lvl_out[k] = busy & (ck >= (rk >> 1)), a duty-cycle level per stage.
//   Example: r=4 gives 50% duty. lvl_out resets to 0.
//  DFE_RATE_LEVEL_EN undefined: the lvl_out port and its logic are absent. All else is identical.
// STRUCTURE
//  Package dfe_rate_pkg: state encoding (IDLE/RUN/PEND), MIN_RATIO=2, default CNT_W, DEF_RATIO.
//  Sub-module dfe_rate_stage_cnt, one instance per stage.
//   Inputs: en, clr, load, ratio. Outputs: cnt, term.
//   The top level holds the FSM, shadow/active registers, handshake and strobe chaining.
// TESTING
//  1. Reset; start with defaults {3,3,3} -> stb_out[0] every 3 cycles, first in cycle 3;
//     frame_stb every 27 cycles.
//  2. In IDLE, cfg {2,4,2} -> cfg_ready=1, transfer on 1st edge; start -> frame period 16.
//  3. In RUN, cfg {5,2,2} at cycle 7 of a 27-cycle frame -> PEND, cfg_ready=0.
//     Old timing holds until frame_stb; then 20-cycle frames.
//  4. cfg {1,3,3} -> cfg_err one pulse, timing unchanged.
//     cfg {0,..} same result. start+stop together -> stays IDLE.
//  5. stop in PEND -> IDLE next cycle, counters 0, later start uses the old ratios.
//     rst mid-frame -> all outputs reset values.
//  6. DFE_RATE_LEVEL_EN with r0=4 -> lvl_out[0] pattern 0,0,1,1 repeating.
//     Build without the macro -> compiles, port absent.

Source files
------------

// File: rtl/dfe_rate_pkg.sv
// ---------------------------------------------------------------------------
// dfe_rate_pkg
// Shared definitions for the DFE decimation-chain rate scheduler:
//   state_e          controller state encoding (IDLE / RUN / PEND)
//   MIN_RATIO        smallest legal per-stage decimation ratio
//   DFE_DEF_*        default build values for the top-level parameters
// ---------------------------------------------------------------------------
package dfe_rate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // counters held at zero, no strobes
    ST_RUN  = 2'd1,  // counting with the active ratio set
    ST_PEND = 2'd2   // counting, a shadow ratio set waits for the frame boundary
  } state_e;

  localparam int MIN_RATIO        = 2;
  localparam int DFE_DEF_N_STAGES = 3;
  localparam int DFE_DEF_CNT_W    = 4;
  localparam int DFE_DEF_RATIO    = 3;

endpackage

// File: rtl/dfe_rate_stage_cnt.sv
// ---------------------------------------------------------------------------
// dfe_rate_stage_cnt
// One decimation stage phase counter. Counts 0 .. ratio-1 on enabled cycles
// and flags the terminal count.
// Ports:
//   clk_in  in   system clock (rising edge)
//   rst     in   synchronous active-high reset, counter -> 0
//   en      in   advance the counter this cycle
//   clr     in   hold/force the counter to 0 (controller idle or stopping)
//   load    in   a new ratio becomes active on this edge; restart phase at 0
//   ratio   in   active decimation ratio for this stage
//   cnt     out  current phase count
//   term    out  cnt is at ratio-1 (terminal count)
// ---------------------------------------------------------------------------
module dfe_rate_stage_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] ratio,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  // ratio is never below 2 once validated, so ratio-1 never underflows.
  assign term = (cnt == (ratio - CNT_W'(1)));

  always_ff @(posedge clk_in) begin
    if (rst || clr || load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= term ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dfe_rate_ctrl.sv
// ---------------------------------------------------------------------------
// dfe_rate_ctrl
// Rate scheduler for the DFE decimation chain. Emits single-cycle clock-enable
// strobes for N_STAGES cascaded stages from one clock. Ratio sets arrive on a
// valid/ready port and are applied only at a frame boundary while running.
//
// Optional feature macro: DFE_RATE_LEVEL_EN adds lvl_out, a per-stage
// duty-cycle level (high for the upper half of each stage's count).
//
// Ports:
//   clk_in     in   system clock
//   rst        in   synchronous active-high reset
//   start      in   IDLE -> RUN (ignored while busy, loses to stop)
//   stop       in   RUN/PEND -> IDLE (pending shadow set discarded)
//   cfg_valid  in   ratio set offered
//   cfg_ratio  in   stage k ratio in [k*CNT_W +: CNT_W]
//   cfg_ready  out  controller can take a ratio set (low only in PEND)
//   cfg_err    out  one-cycle pulse, cycle after a rejected transfer
//   stb_out    out  per-stage single-cycle enable strobes
//   frame_stb  out  last-stage strobe, the frame boundary
//   busy       out  state != IDLE
//   lvl_out    out  per-stage duty level (DFE_RATE_LEVEL_EN only)
//   state_dbg  out  current controller state
//   cnt_dbg    out  stage counters, stage k in [k*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module dfe_rate_ctrl
  import dfe_rate_pkg::*;
#(
  parameter int N_STAGES  = DFE_DEF_N_STAGES,
  parameter int CNT_W     = DFE_DEF_CNT_W,
  parameter int DEF_RATIO = DFE_DEF_RATIO
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      cfg_valid,
  input  logic [N_STAGES*CNT_W-1:0] cfg_ratio,
  output logic                      cfg_ready,
  output logic                      cfg_err,
  output logic [N_STAGES-1:0]       stb_out,
  output logic                      frame_stb,
  output logic                      busy,
`ifdef DFE_RATE_LEVEL_EN
  output logic [N_STAGES-1:0]       lvl_out,
`endif
  output state_e                    state_dbg,
  output logic [N_STAGES*CNT_W-1:0] cnt_dbg
);

  // Config handshake: a ratio set transfers on any rising edge where
  // cfg_valid & cfg_ready are both high. cfg_ready depends only on state,
  // never on cfg_valid. A rejected set still completes the transfer.

  state_e                    state_q, state_d;
  logic [N_STAGES*CNT_W-1:0] active_q;
  logic [N_STAGES*CNT_W-1:0] shadow_q;
  logic [N_STAGES-1:0]       term;
  logic [N_STAGES-1:0]       stage_en;
  logic                      cfg_xfer;
  logic                      cfg_ok;
  logic                      apply_shadow;
  logic                      cnt_clr;

  assign cfg_xfer = cfg_valid & cfg_ready;

  // Whole set is rejected if any field is below MIN_RATIO.
  always_comb begin
    cfg_ok = 1'b1;
    for (int k = 0; k < N_STAGES; k++) begin
      if (cfg_ratio[k*CNT_W +: CNT_W] < CNT_W'(MIN_RATIO)) cfg_ok = 1'b0;
    end
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk_in) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_RUN;
      ST_RUN: begin
        if (stop)                   state_d = ST_IDLE;
        else if (cfg_xfer && cfg_ok) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (stop)           state_d = ST_IDLE;
        else if (frame_stb) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs (pure decode of registered state) ----
  always_comb begin
    logic chain;
    busy      = (state_q != ST_IDLE);
    cfg_ready = (state_q != ST_PEND);
    chain     = busy;
    for (int k = 0; k < N_STAGES; k++) begin
      chain      = chain & term[k];
      stb_out[k] = chain;
    end
    frame_stb = stb_out[N_STAGES-1];
  end

  assign state_dbg = state_q;

  // At the boundary every counter is already terminal, so they all wrap
  // together; load makes the restart explicit as the new set goes live.
  assign apply_shadow = (state_q == ST_PEND) && frame_stb && !stop;
  assign cnt_clr      = (state_q == ST_IDLE) || stop;

  // ---- Active / shadow ratio registers and error pulse ----
  always_ff @(posedge clk_in) begin
    if (rst) begin
      active_q <= {N_STAGES{CNT_W'(DEF_RATIO)}};
      shadow_q <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_xfer && !cfg_ok;
      if (state_q == ST_IDLE) begin
        if (cfg_xfer && cfg_ok) active_q <= cfg_ratio;
      end else if (stop) begin
        shadow_q <= '0;
      end else if (state_q == ST_RUN) begin
        if (cfg_xfer && cfg_ok) shadow_q <= cfg_ratio;
      end else if (apply_shadow) begin
        active_q <= shadow_q;
      end
    end
  end

  // Stage 0 advances every busy cycle; stage k advances on stage k-1's strobe.
  assign stage_en = {stb_out[N_STAGES-2:0], busy};

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    dfe_rate_stage_cnt #(.CNT_W(CNT_W)) u_stage (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (stage_en[k]),
      .clr    (cnt_clr),
      .load   (apply_shadow),
      .ratio  (active_q[k*CNT_W +: CNT_W]),
      .cnt    (cnt_dbg[k*CNT_W +: CNT_W]),
      .term   (term[k])
    );
  end

`ifdef DFE_RATE_LEVEL_EN
  // High for the upper half of each stage's count; r=4 gives 0,0,1,1.
  always_comb begin
    for (int k = 0; k < N_STAGES; k++) begin
      lvl_out[k] = busy &&
        (cnt_dbg[k*CNT_W +: CNT_W] >= (active_q[k*CNT_W +: CNT_W] >> 1));
    end
  end
`endif

endmodule

// File: tb/tb_dfe_rate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dfe_rate_ctrl
// Self-checking bench for dfe_rate_ctrl. The reference model tracks elapsed
// cycles since the last frame start and derives strobes from ratio products;
// expected outputs are queued per cycle and checked by a separate monitor.
// ---------------------------------------------------------------------------
module tb_dfe_rate_ctrl;
  import dfe_rate_pkg::*;

  localparam int N = 3;
  localparam int W = 4;
`ifdef DFE_RATE_LEVEL_EN
  localparam int EW = 10;
`else
  localparam int EW = 7;
`endif

  // ---- clock / reset ----
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic           rst, start, stop, cfg_valid;
  logic [N*W-1:0] cfg_ratio;
  logic           cfg_ready, cfg_err, frame_stb, busy;
  logic [N-1:0]   stb_out;
  state_e         state_dbg;
  logic [N*W-1:0] cnt_dbg;
`ifdef DFE_RATE_LEVEL_EN
  logic [N-1:0]   lvl_out;
`endif

  dfe_rate_ctrl dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_ratio (cfg_ratio),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .stb_out   (stb_out),
    .frame_stb (frame_stb),
    .busy      (busy),
`ifdef DFE_RATE_LEVEL_EN
    .lvl_out   (lvl_out),
`endif
    .state_dbg (state_dbg),
    .cnt_dbg   (cnt_dbg)
  );

  // ---- scoreboard ----
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit stim_done = 0;

  // ---- reference model ----
  bit m_busy, m_pend, m_err;
  int m_r[N];
  int m_sh[N];
  int m_t;  // cycles elapsed in the current frame (0 = first counting cycle)

  function automatic void model_reset();
    m_busy = 0; m_pend = 0; m_err = 0; m_t = 0;
    for (int k = 0; k < N; k++) begin m_r[k] = 3; m_sh[k] = 0; end
  endfunction

  // Expected outputs: {lvl, busy, cfg_ready, cfg_err, frame_stb, stb[N-1:0]}
  function automatic logic [EW-1:0] model_out();
    logic [N-1:0] s;
    logic [EW-1:0] e;
    int p;
    p = 1;
    for (int k = 0; k < N; k++) begin
      p = p * m_r[k];
      s[k] = m_busy && (((m_t + 1) % p) == 0);
    end
    e = '0;
    e[N-1:0] = s;
    e[3] = s[N-1];
    e[4] = m_err;
    e[5] = !m_pend;
    e[6] = m_busy;
`ifdef DFE_RATE_LEVEL_EN
    p = 1;
    for (int k = 0; k < N; k++) begin
      e[7+k] = m_busy && (((m_t / p) % m_r[k]) >= (m_r[k] / 2));
      p = p * m_r[k];
    end
`endif
    return e;
  endfunction

  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  // ---- driver: one clock cycle of stimulus plus model update ----
  task automatic step(input bit r, input bit s, input bit p, input bit v,
                      input logic [N*W-1:0] cr);
    logic [EW-1:0] e;
    bit fs, xfer, ok, was;
    int nr[N];
    rst = r; start = s; stop = p; cfg_valid = v; cfg_ratio = cr;
    e = model_out();
    exp_q.push_back(e);
    fs = e[3];
    ok = 1;
    for (int k = 0; k < N; k++) begin
      nr[k] = int'(cr[k*W +: W]);
      if (nr[k] < 2) ok = 0;
    end
    xfer = v && !m_pend;
    @(posedge clk_in);
    if (r) begin
      model_reset();
    end else begin
      m_err = xfer && !ok;
      if (!m_busy) begin
        if (xfer && ok) m_r = nr;
        if (s && !p) begin m_busy = 1; m_t = 0; end
      end else if (p) begin
        m_busy = 0; m_pend = 0; m_t = 0;
      end else begin
        was = m_pend;
        m_t = fs ? 0 : m_t + 1;
        if (was && fs) begin m_r = m_sh; m_pend = 0; end
        if (!was && xfer && ok) begin m_sh = nr; m_pend = 1; end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
  endtask

  task automatic cfg(input logic [N*W-1:0] cr);
    step(0, 0, 0, 1, cr);
  endtask

  // ---- monitor ----
  initial begin
    logic [EW-1:0] e, a;
    forever begin
      @(negedge clk_in);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '0;
        a[N-1:0] = stb_out;
        a[3] = frame_stb;
        a[4] = cfg_err;
        a[5] = cfg_ready;
        a[6] = busy;
`ifdef DFE_RATE_LEVEL_EN
        a[9:7] = lvl_out;
`endif
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL out_vec t=%0t actual=%b expected=%b (lvl,busy,rdy,err,frame,stb)",
                   $time, a, e);
        end
      end
    end
  end

  // ---- stimulus ----
  initial begin
    int a, b, c;
    rst = 1; start = 0; stop = 0; cfg_valid = 0; cfg_ratio = '0;
    repeat (2) @(posedge clk_in);
    #1;
    model_reset();

    // Reset state, then defaults {3,3,3}: 27-cycle frames.
    idle(3);
    step(0, 1, 0, 0, '0);
    idle(60);

    // Idle reconfigure {2,4,2}: 16-cycle frames.
    step(0, 0, 1, 0, '0);
    cfg(pk(2, 4, 2));
    step(0, 1, 0, 0, '0);
    idle(40);

    // Back to defaults, then {5,2,2} offered mid-frame while running.
    step(0, 0, 1, 0, '0);
    cfg(pk(3, 3, 3));
    step(0, 1, 0, 0, '0);
    idle(6);
    cfg(pk(5, 2, 2));
    cfg(pk(5, 2, 2));  // not ready in PEND, no transfer
    idle(70);

    // Rejected sets: field of 1, field of 0.
    cfg(pk(1, 3, 3));
    idle(3);
    cfg(pk(0, 3, 3));
    idle(30);

    // start with stop in idle stays idle.
    step(0, 0, 1, 0, '0);
    step(0, 1, 1, 0, '0);
    idle(3);

    // stop while PEND discards the shadow; restart keeps {5,2,2}.
    step(0, 1, 0, 0, '0);
    idle(5);
    cfg(pk(4, 4, 4));
    idle(3);
    step(0, 0, 1, 0, '0);
    idle(2);
    step(0, 1, 0, 0, '0);
    idle(40);

    // Reset mid-frame.
    idle(7);
    step(1, 0, 0, 0, '0);
    idle(5);

    // r0=4 duty pattern, then maximum ratio fields.
    cfg(pk(4, 2, 2));
    step(0, 1, 0, 0, '0);
    idle(20);
    step(0, 0, 1, 0, '0);
    cfg(pk(15, 15, 2));
    step(0, 1, 0, 0, '0);
    idle(460);

    // Randomized traffic.
    step(0, 0, 1, 0, '0);
    cfg(pk(2, 3, 2));
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 15);
      end else begin
        a = $urandom_range(2, 5); b = $urandom_range(2, 4); c = $urandom_range(2, 4);
      end
      step($urandom_range(0, 999) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 7) == 0,
           pk(a, b, c));
    end

    idle(2);
    @(negedge clk_in);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain actual=%0d entries required=0", exp_q.size());
    end
    stim_done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
